// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter: the DMA state encoding, the fixed
// bus addresses and small address/state helpers.
package oam_dma_arbiter_pkg;

  // DMA sequencer states, in the order one byte moves through them.
  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_SETUP = 3'd1,
    DMA_READ  = 3'd2,
    DMA_CAPT  = 3'd3,
    DMA_WRITE = 3'd4,
    DMA_DONE  = 3'd5
  } dma_state_e;

  // A CPU write here starts a transfer; the data byte is the source page.
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  // First OAM byte written by the DMA.
  localparam logic [15:0] DMA_DEST_BASE = 16'hFE00;
  // Lowest CPU address still served while a transfer runs (through FFFF).
  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  // Default number of bytes per transfer.
  localparam int          DMA_LENGTH_DEFAULT = 160;

  // The DMA owns the bus from SETUP through WRITE; DONE behaves like IDLE.
  function automatic logic dma_is_busy(input dma_state_e s);
    return s inside {DMA_SETUP, DMA_READ, DMA_CAPT, DMA_WRITE};
  endfunction

  // HRAM stays reachable by the CPU during a transfer.
  function automatic logic is_hram(input logic [15:0] addr);
    return addr >= HRAM_BASE;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_sequencer.sv
// OAM DMA sequencer: state machine, byte index, source page and the byte held
// between the read and write phases. The top level decides when to trigger
// and when the CPU steals a bus phase (stall).
module oam_dma_sequencer
  import oam_dma_arbiter_pkg::*;
#(
  parameter int DMA_LENGTH = DMA_LENGTH_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trig_i,      // start (or restart) a transfer
  input  logic [7:0] trig_src_i,  // source page for the new transfer
  input  logic       stall_i,     // CPU owns the bus during READ/WRITE
  input  logic [7:0] rd_data_i,   // MMU read data (1-cycle latency)
  output dma_state_e state_o,
  output logic [7:0] index_o,
  output logic [7:0] src_o,
  output logic [7:0] byte_o
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

  dma_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] src_q,   src_d;
  logic [7:0] byte_q,  byte_d;

  // State and datapath registers; reset aborts any transfer immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMA_IDLE;
      index_q <= '0;
      src_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      src_q   <= src_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic: three bus phases per byte, holding on a stall.
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    src_d   = src_q;
    byte_d  = byte_q;
    if (trig_i) begin
      src_d   = trig_src_i;
      index_d = '0;
      state_d = DMA_SETUP;
    end else begin
      case (state_q)
        DMA_IDLE: state_d = DMA_IDLE;
        DMA_SETUP: begin
          index_d = '0;
          state_d = DMA_READ;
        end
        DMA_READ: begin
          if (!stall_i) state_d = DMA_CAPT;
        end
        DMA_CAPT: begin
          byte_d  = rd_data_i;
          state_d = DMA_WRITE;
        end
        DMA_WRITE: begin
          if (!stall_i) begin
            if (index_q == LAST_IDX) begin
              state_d = DMA_DONE;
            end else begin
              index_d = index_q + 8'd1;
              state_d = DMA_READ;
            end
          end
        end
        DMA_DONE: state_d = DMA_IDLE;
        default:  state_d = DMA_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign index_o = index_q;
  assign src_o   = src_q;
  assign byte_o  = byte_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: sole master of the MMU bus. Passes CPU accesses through
// when no transfer runs; during a transfer only HRAM is served to the CPU and
// everything else is blocked (writes dropped, reads return FF).
// Optional feature macro: OAM_DMA_RESTART_EN -- a CPU write to the DMA register
// during a transfer restarts it from the new source instead of being ignored.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int DMA_LENGTH = DMA_LENGTH_DEFAULT
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  input  logic        iCpuRe,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMmuAddr,
  output logic [7:0]  oMmuData,
  output logic        oMmuWe,
  input  logic [7:0]  iMmuData,
  output logic        oDmaBusy,
  output logic        oDmaDone
);

  dma_state_e dma_state;
  logic [7:0] dma_index;
  logic [7:0] dma_src;
  logic [7:0] dma_byte;

  logic dma_busy;
  logic cpu_hram;
  logic cpu_owns_bus;
  logic reg_write;
  logic trig_idle;
  logic trig_busy;
  logic dma_stall;

  logic rd_pend_q, rd_pend_d;  // CPU read served last cycle
  logic blk_rd_q,  blk_rd_d;   // CPU read blocked last cycle

  assign dma_busy  = dma_is_busy(dma_state);
  assign cpu_hram  = is_hram(iCpuAddr);
  assign reg_write = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

  // HRAM accesses win over the DMA; in READ/WRITE the DMA then holds.
  assign cpu_owns_bus = dma_busy && (iCpuWe || iCpuRe) && cpu_hram;
  assign dma_stall    = cpu_owns_bus &&
                        ((dma_state == DMA_READ) || (dma_state == DMA_WRITE));

  // DONE follows IDLE rules, so a trigger there is honoured.
  assign trig_idle = !dma_busy && reg_write;
`ifdef OAM_DMA_RESTART_EN
  assign trig_busy = dma_busy && reg_write;
`else
  assign trig_busy = 1'b0;
`endif

  oam_dma_sequencer #(
    .DMA_LENGTH (DMA_LENGTH)
  ) u_seq (
    .clk_i      (iClock),
    .rst_ni     (iReset_n),
    .trig_i     (trig_idle || trig_busy),
    .trig_src_i (iCpuData),
    .stall_i    (dma_stall),
    .rd_data_i  (iMmuData),
    .state_o    (dma_state),
    .index_o    (dma_index),
    .src_o      (dma_src),
    .byte_o     (dma_byte)
  );

  // Bus mux: CPU pass-through unless the DMA owns this cycle.
  always_comb begin
    oMmuAddr = iCpuAddr;
    oMmuData = iCpuData;
    oMmuWe   = iCpuWe;
    if (dma_busy && !cpu_owns_bus) begin
      // Blocked CPU accesses never reach the MMU; idle DMA phases park
      // the address on the source byte with the write enable low.
      oMmuAddr = {dma_src, dma_index};
      oMmuData = dma_byte;
      oMmuWe   = 1'b0;
      if (dma_state == DMA_WRITE) begin
        oMmuAddr = DMA_DEST_BASE + {8'h00, dma_index};
        // A restart abandons the byte that was about to be written.
        oMmuWe   = !trig_busy;
      end
    end
  end

  // Classify this cycle's CPU read as served or blocked.
  always_comb begin
    rd_pend_d = iCpuRe && (!dma_busy || cpu_hram);
    blk_rd_d  = iCpuRe && dma_busy && !cpu_hram;
  end

  // Read-tracking flags, one cycle behind the request like the MMU data.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      rd_pend_q <= 1'b0;
      blk_rd_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      blk_rd_q  <= blk_rd_d;
    end
  end

  // Blocked reads and idle cycles present FF; served reads show MMU data.
  assign oCpuData = (blk_rd_q || !rd_pend_q) ? 8'hFF : iMmuData;

  assign oDmaBusy = dma_busy;
  assign oDmaDone = (dma_state == DMA_DONE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: a byte-array MMU with 1-cycle read
// latency, a shadow memory holding the expected contents, and transfer timing
// derived from the 1 + 3*N cycle rule plus one cycle per stolen DMA phase.
module tb_oam_dma_arbiter;

  localparam int LEN = 160;

  logic        iClock;
  logic        iReset_n;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic        iCpuRe;
  logic [7:0]  oCpuData;
  logic [15:0] oMmuAddr;
  logic [7:0]  oMmuData;
  logic        oMmuWe;
  logic [7:0]  iMmuData;
  logic        oDmaBusy;
  logic        oDmaDone;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  oam_dma_arbiter dut (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iCpuAddr (iCpuAddr),
    .iCpuData (iCpuData),
    .iCpuWe   (iCpuWe),
    .iCpuRe   (iCpuRe),
    .oCpuData (oCpuData),
    .oMmuAddr (oMmuAddr),
    .oMmuData (oMmuData),
    .oMmuWe   (oMmuWe),
    .iMmuData (iMmuData),
    .oDmaBusy (oDmaBusy),
    .oDmaDone (oDmaDone)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // MMU model: synchronous write, registered read, plus a backdoor loader.
  always @(posedge iClock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (oMmuWe) mem[oMmuAddr] <= oMmuData;
    iMmuData <= mem[oMmuAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot = n_tot + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v; shadow[a] = v;
    @(posedge iClock); #1;
    bd_we = 1'b0;
  endtask

  // Fill the first LEN bytes of a page: ramp (value == offset) or random.
  task automatic load_page(input logic [7:0] p, input bit ramp);
    for (int i = 0; i < LEN; i++) begin
      poke({p, 8'(i)}, ramp ? 8'(i) : 8'($urandom));
    end
  endtask

  // Expected effect of a transfer that wrote the first n bytes.
  task automatic model_copy(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) shadow[16'hFE00 + 16'(i)] = shadow[{p, 8'(i)}];
  endtask

  task automatic cmp_region(input string tag, input logic [15:0] base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (mem[base + 16'(i)] !== shadow[base + 16'(i)]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  // CPU write to the DMA register; it must reach the MMU.
  task automatic start_dma(input logic [7:0] src);
    iCpuAddr = 16'hFF46; iCpuData = src; iCpuWe = 1'b1;
    #1;
    chk("trig_fwd_we", 32'(oMmuWe), 32'd1);
    chk("trig_fwd_addr", 32'(oMmuAddr), 32'hFF46);
    shadow[16'hFF46] = src;
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuAddr = '0; iCpuData = '0;
  endtask

  // Follow a transfer cycle by cycle until oDmaDone. At busy-cycle act_cyc
  // (0 = SETUP) perform one action: 1 write, 2 read, 3 DMA-register write,
  // 4 assert reset. Returns at #1 after the DONE edge, inputs idle.
  task automatic monitor(input int act_cyc, input int kind, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] rd_exp,
                         output int busy_n, output int done_n);
    bit rd_pend;
    bit fin;
    busy_n = 0; done_n = 0; rd_pend = 0; fin = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (rd_pend) begin
        chk("dma_cpu_rd", 32'(oCpuData), 32'(rd_exp));
        rd_pend = 0;
      end
      if (oDmaBusy) busy_n++;
      if (oDmaDone) begin
        done_n++;
        fin = 1;
      end
      if (!fin && c == act_cyc) begin
        iCpuAddr = a; iCpuData = d;
        case (kind)
          1, 3: iCpuWe = 1'b1;
          2: begin iCpuRe = 1'b1; rd_pend = 1; end
          4: begin
            iReset_n = 1'b0;
            #1;
            chk("rst_busy", 32'(oDmaBusy), 32'd0);
            chk("rst_done", 32'(oDmaDone), 32'd0);
            chk("rst_we", 32'(oMmuWe), 32'd0);
            fin = 1;
          end
          default: ;
        endcase
      end
      if (!fin) begin
        @(posedge iClock); #1;
        iCpuWe = 1'b0; iCpuRe = 1'b0; iCpuAddr = '0; iCpuData = '0;
      end
    end
    chk("dma_finished", 32'(fin), 32'd1);
  endtask

  task automatic after_done();
    @(posedge iClock); #1;
    chk("done_single", 32'(oDmaDone), 32'd0);
    chk("busy_after", 32'(oDmaBusy), 32'd0);
  endtask

  initial begin
    int busy_n, done_n, k;
    logic [7:0] p1, p2, hv;

    iReset_n = 1'b0; iCpuAddr = '0; iCpuData = '0; iCpuWe = 1'b0; iCpuRe = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge iClock);
    #1;
    // Reset values
    chk("reset_busy", 32'(oDmaBusy), 32'd0);
    chk("reset_done", 32'(oDmaDone), 32'd0);
    chk("reset_we", 32'(oMmuWe), 32'd0);
    chk("reset_addr", 32'(oMmuAddr), 32'd0);
    chk("reset_cpudata", 32'(oCpuData), 32'hFF);
    iReset_n = 1'b1;
    @(posedge iClock); #1;
    chk("idle_busy", 32'(oDmaBusy), 32'd0);

    // Pass-through write then read in IDLE
    iCpuAddr = 16'hC000; iCpuData = 8'h5A; iCpuWe = 1'b1;
    #1;
    chk("idle_wr_addr", 32'(oMmuAddr), 32'hC000);
    chk("idle_wr_data", 32'(oMmuData), 32'h5A);
    chk("idle_wr_we", 32'(oMmuWe), 32'd1);
    shadow[16'hC000] = 8'h5A;
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuRe = 1'b1;
    @(posedge iClock); #1;
    iCpuRe = 1'b0; iCpuAddr = '0; iCpuData = '0;
    chk("idle_rd_data", 32'(oCpuData), 32'h5A);

    // Plain transfer from page C1 holding a ramp
    load_page(8'hC1, 1'b1);
    start_dma(8'hC1);
    monitor(-1, 0, '0, '0, '0, busy_n, done_n);
    chk("t2_busy_cycles", 32'(busy_n), 32'd481);
    chk("t2_done_pulses", 32'(done_n), 32'd1);
    after_done();
    model_copy(8'hC1, LEN);
    cmp_region("t2_oam", 16'hFE00, LEN);

    // Blocked read of C000 during a transfer returns FF
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    start_dma(p1);
    monitor(int'($urandom_range(470, 1)), 2, 16'hC000, '0, 8'hFF, busy_n, done_n);
    chk("t3a_busy_cycles", 32'(busy_n), 32'd481);
    after_done();
    model_copy(p1, LEN);
    cmp_region("t3a_oam", 16'hFE00, LEN);

    // Blocked write of 77 to C000 is dropped
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    start_dma(p1);
    monitor(int'($urandom_range(470, 1)), 1, 16'hC000, 8'h77, '0, busy_n, done_n);
    chk("t3b_busy_cycles", 32'(busy_n), 32'd481);
    after_done();
    model_copy(p1, LEN);
    cmp_region("t3b_c000", 16'hC000, 1);
    cmp_region("t3b_oam", 16'hFE00, LEN);

    // HRAM write during a READ phase: served, transfer one cycle longer
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    k = int'($urandom_range(LEN - 1, 0));
    start_dma(p1);
    monitor(1 + 3 * k, 1, 16'hFF90, 8'h33, '0, busy_n, done_n);
    chk("t4a_busy_cycles", 32'(busy_n), 32'd482);
    after_done();
    shadow[16'hFF90] = 8'h33;
    model_copy(p1, LEN);
    cmp_region("t4a_hram", 16'hFF90, 1);
    cmp_region("t4a_oam", 16'hFE00, LEN);

    // HRAM write during CAPT: bus is free, no extension
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    k = int'($urandom_range(LEN - 1, 0));
    hv = 8'($urandom);
    start_dma(p1);
    monitor(2 + 3 * k, 1, 16'hFFC3, hv, '0, busy_n, done_n);
    chk("t4b_busy_cycles", 32'(busy_n), 32'd481);
    after_done();
    shadow[16'hFFC3] = hv;
    model_copy(p1, LEN);
    cmp_region("t4b_hram", 16'hFFC3, 1);
    cmp_region("t4b_oam", 16'hFE00, LEN);

    // HRAM read during a WRITE phase, then a new trigger in the DONE cycle
    poke(16'hFFA0, 8'($urandom));
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    p2 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    k = int'($urandom_range(LEN - 1, 0));
    start_dma(p1);
    monitor(3 + 3 * k, 2, 16'hFFA0, '0, shadow[16'hFFA0], busy_n, done_n);
    chk("t4c_busy_cycles", 32'(busy_n), 32'd482);
    model_copy(p1, LEN);
    cmp_region("t4c_oam", 16'hFE00, LEN);
    start_dma(p2);
    monitor(-1, 0, '0, '0, '0, busy_n, done_n);
    chk("chain_busy_cycles", 32'(busy_n), 32'd481);
    chk("chain_done_pulses", 32'(done_n), 32'd1);
    after_done();
    model_copy(p2, LEN);
    cmp_region("chain_oam", 16'hFE00, LEN);

    // Reset at byte 80: first 80 bytes copied, rest of OAM untouched
    p1 = 8'($urandom_range(8'hDF, 8'h80));
    load_page(p1, 1'b0);
    start_dma(p1);
    monitor(1 + 3 * 80, 4, '0, '0, '0, busy_n, done_n);
    chk("t5_busy_cycles", 32'(busy_n), 32'd242);
    @(posedge iClock); #1;
    chk("t5_busy_held", 32'(oDmaBusy), 32'd0);
    chk("t5_cpudata", 32'(oCpuData), 32'hFF);
    iReset_n = 1'b1;
    @(posedge iClock); #1;
    model_copy(p1, 80);
    cmp_region("t5_oam_partial", 16'hFE00, LEN);
    start_dma(p1);
    monitor(-1, 0, '0, '0, '0, busy_n, done_n);
    chk("t5_retry_busy", 32'(busy_n), 32'd481);
    after_done();
    model_copy(p1, LEN);
    cmp_region("t5_retry_oam", 16'hFE00, LEN);

    // DMA-register write at byte 40
    p1 = 8'($urandom_range(8'h9F, 8'h80));
    p2 = 8'($urandom_range(8'hBF, 8'hA0));
    load_page(p1, 1'b0);
    load_page(p2, 1'b0);
    start_dma(p1);
    monitor(1 + 3 * 40, 3, 16'hFF46, p2, '0, busy_n, done_n);
`ifdef OAM_DMA_RESTART_EN
    chk("t6_busy_cycles", 32'(busy_n), 32'd603);
    model_copy(p2, LEN);
`else
    chk("t6_busy_cycles", 32'(busy_n), 32'd481);
    model_copy(p1, LEN);
`endif
    chk("t6_done_pulses", 32'(done_n), 32'd1);
    after_done();
    cmp_region("t6_oam", 16'hFE00, LEN);
    cmp_region("t6_dmareg_mem", 16'hFF46, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
